ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_keyboard_rx_if.sv | 16 +
 rtl/ps2_sync_filter.sv | 53 +++++
 rtl/ps2_keyboard_rx.sv | 124 ++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, frame constants and scan codes for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic ODD_PARITY = 1'b1;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    // A frame is accepted only with a high stop bit and odd parity over data+parity
    function automatic logic frame_ok(input logic [DATA_BITS-1:0] data_bits,
                                      input logic parity_bit,
                                      input logic stop_bit);
        return stop_bit && ((^{data_bits, parity_bit}) == ODD_PARITY);
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 pins plus received key byte/strobe bundle
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_data;
    logic       key_valid;
    logic       frame_err;

    // master: the keyboard side driving the pins and watching results
    modport master (output ps2_clk, output ps2_data,
                    input key_data, input key_valid, input frame_err);

    // slave: the receiver consuming the pins and producing key bytes
    modport slave (input ps2_clk, input ps2_data,
                   output key_data, output key_valid, output frame_err);
endinterface

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - pin synchronizer, level deglitch filter and falling-edge detect
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   prev_q, prev_d;
    logic                   fall_q, fall_d;

    // Level only flips after FILT_LEN consecutive disagreeing samples; fall is registered
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d = level_q;
        fall_d = prev_q & ~level_q;
    end

    // State registers; the pin idles high so everything resets to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            fall_q  <= fall_d;
        end
    end

    assign fall = fall_q;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 device-to-host frame receiver producing key bytes
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               sysclk,
    input  logic               rst,
    ps2_keyboard_rx_if.slave   bus
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                   fall;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic                   data_s;

    ps2_state_e             state_q, state_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          to_q, to_d;
    logic [7:0]             key_data_q, key_data_d;
    logic                   key_valid_q, key_valid_d;
    logic                   frame_err_q, frame_err_d;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_clk_filter (
        .clk  (sysclk),
        .rst  (rst),
        .din  (bus.ps2_clk),
        .fall (fall)
    );

    assign data_s = dsync_q[SYNC_STAGES-1];

    // Frame deframing, parity/stop check and inactivity timeout
    always_comb begin
        dsync_d     = {dsync_q[SYNC_STAGES-2:0], bus.ps2_data};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_d        = to_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE) begin
            to_d = '0;
            // A fall with data high is a stray edge, not a start bit
            if (fall && !data_s) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                shift_d   = '0;
            end
        end else if (fall) begin
            // An edge always beats a simultaneous timeout
            to_d = '0;
            case (state_q)
                DATA: begin
                    shift_d   = {data_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (frame_ok(shift_q, par_q, data_s)) begin
                        key_data_d  = shift_q;
                        key_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            to_d        = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    // Receiver state and registered outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            dsync_q     <= '1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_q        <= '0;
            key_data_q  <= 8'h00;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            dsync_q     <= dsync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.key_data  = key_data_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - randomized self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int S = 2;
    localparam int F = 8;
    localparam int T = 300;
    localparam int H = 20;
    localparam int L = S + F + 2;

    typedef struct {
        int         at;
        bit         is_err;
        logic [7:0] b;
    } ev_t;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    always #5 sysclk = ~sysclk;

    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(
        .SYNC_STAGES    (S),
        .FILT_LEN       (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         n_valid_seen = 0;
    int         n_err_seen = 0;
    ev_t        evq[$];
    logic [7:0] m_held = 8'h00;
    bit         m_v;
    bit         m_e;

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    // Reference model and per-cycle compare, evaluated on the falling clock edge
    initial begin
        ev_t e;
        forever begin
            @(negedge sysclk);
            cyc++;
            m_v = 1'b0;
            m_e = 1'b0;
            if (rst) begin
                m_held = 8'h00;
                evq.delete();
            end else if (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.is_err) m_e = 1'b1;
                else begin
                    m_v    = 1'b1;
                    m_held = e.b;
                end
            end
            if (bus.key_valid === 1'b1) n_valid_seen++;
            if (bus.frame_err === 1'b1) n_err_seen++;
            n_total++;
            if ({bus.key_data, bus.key_valid, bus.frame_err} === {m_held, m_v, m_e}) n_pass++;
            else $display("FAIL cycle %0d outputs: got data=%h valid=%b err=%b expected data=%h valid=%b err=%b",
                          cyc, bus.key_data, bus.key_valid, bus.frame_err, m_held, m_v, m_e);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sysclk);
            #1;
        end
    endtask

    task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clk_glitch();
        bus.ps2_clk = 1'b0;
        tick(3);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input bit glitch);
        logic [10:0] bits;
        ev_t         e;
        bits     = {~bad_stop, odd_par(b) ^ flip_par, b, 1'b0};
        e.at     = cyc + 21 * H + L;
        e.is_err = flip_par | bad_stop;
        e.b      = b;
        evq.push_back(e);
        for (int i = 0; i < 11; i++) begin
            bus.ps2_data = bits[i];
            if (glitch && i == 5) begin
                tick(5);
                clk_glitch();
                tick(H - 8);
            end else tick(H);
            bus.ps2_clk = 1'b0;
            tick(H);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_partial(input int nbits, input bit expect_timeout);
        logic [10:0] bits;
        ev_t         e;
        bits = {2'b11, 8'($urandom), 1'b0};
        if (expect_timeout) begin
            e.at     = cyc + (2 * (nbits - 1) + 1) * H + L + T;
            e.is_err = 1'b1;
            e.b      = 8'h00;
            evq.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            tick(H);
            bus.ps2_clk = 1'b0;
            tick(H);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    initial begin
        int v0;
        int e0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        lit_check("reset_key_data", 32'(bus.key_data), 32'h00);
        rst = 1'b0;
        tick(5);

        lit_check("model_par_1C", 32'(odd_par(8'h1C)), 32'd0);
        lit_check("model_par_F0", 32'(odd_par(8'hF0)), 32'd1);
        lit_check("model_par_23", 32'(odd_par(8'h23)), 32'd0);

        v0 = n_valid_seen;
        e0 = n_err_seen;
        clk_glitch();
        tick(H);
        bus.ps2_clk = 1'b0;
        tick(H);
        bus.ps2_clk = 1'b1;
        tick(2 * H);
        lit_check("idle_noise_pulses", 32'(n_valid_seen - v0 + n_err_seen - e0), 32'd0);

        v0 = n_valid_seen;
        send_frame(KEY_A, 1'b0, 1'b0, 1'b0);
        tick(H);
        lit_check("t1_key_data", 32'(bus.key_data), 32'h1C);
        lit_check("t1_pulses", 32'(n_valid_seen - v0), 32'd1);

        v0 = n_valid_seen;
        send_frame(KEY_BREAK, 1'b0, 1'b0, 1'b0);
        lit_check("t2_first", 32'(bus.key_data), 32'hF0);
        send_frame(KEY_D, 1'b0, 1'b0, 1'b0);
        tick(H);
        lit_check("t2_second", 32'(bus.key_data), 32'h23);
        lit_check("t2_pulses", 32'(n_valid_seen - v0), 32'd2);

        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_frame(KEY_W, 1'b1, 1'b0, 1'b0);
        tick(H);
        lit_check("t3_key_held", 32'(bus.key_data), 32'h23);
        lit_check("t3_errs", 32'(n_err_seen - e0), 32'd1);
        lit_check("t3_no_valid", 32'(n_valid_seen - v0), 32'd0);

        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_frame(KEY_S, 1'b0, 1'b1, 1'b0);
        tick(H);
        lit_check("t4_errs", 32'(n_err_seen - e0), 32'd1);
        lit_check("t4_no_valid", 32'(n_valid_seen - v0), 32'd0);
        send_frame(KEY_S, 1'b0, 1'b0, 1'b1);
        tick(H);
        lit_check("t4_key_data", 32'(bus.key_data), 32'h1B);

        e0 = n_err_seen;
        send_partial(5, 1'b1);
        tick(T + L + 2 * H);
        lit_check("t5_timeout_errs", 32'(n_err_seen - e0), 32'd1);
        send_frame(KEY_A, 1'b0, 1'b0, 1'b0);
        tick(H);
        lit_check("t5_recover", 32'(bus.key_data), 32'h1C);

        send_frame(KEY_W, 1'b0, 1'b0, 1'b1);
        send_frame(KEY_W, 1'b0, 1'b0, 1'b0);
        tick(H);
        lit_check("t6_glitch_frame", 32'(bus.key_data), 32'h1D);

        v0 = n_valid_seen;
        e0 = n_err_seen;
        send_partial(4, 1'b0);
        tick(H);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        lit_check("t6_rst_key_data", 32'(bus.key_data), 32'h00);
        tick(T + 2 * H);
        lit_check("t6_rst_no_pulses", 32'(n_valid_seen - v0 + n_err_seen - e0), 32'd0);

        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 2) == 0));
            tick($urandom_range(H, 3 * H));
        end

        tick(L + 5);
        lit_check("pending_events", 32'(evq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
